card_shoe: RTL and testbench
============================

Name: card_shoe

Overview:
- Upstream card source for the blackjack game controller; replaces the free-running deck stub.
- Holds one 52-card deck with a dealt-card mask, so no card repeats until a reshuffle.
- Picks cards with a free-running LFSR and linear probing, and answers each draw request with exactly one valid-card pulse or one empty pulse.

Parameters:
- LFSR_SEED, 8'hA5, reset value of the 8-bit LFSR; a value of 0 is replaced by 8'h01.
- AUTO_RESHUFFLE, 1, 1 = a request on an empty shoe clears the mask and deals; 0 = the request returns o_empty.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_drawReq  in  1  single-cycle draw request; sampled only in IDLE
- i_shuffle  in  1  clear dealt mask (new game)
- i_stir  in  1  entropy input (deal button held); adds an extra LFSR step per cycle
- o_card  out  6  card_t {suit[5:4], rank[3:0]}, rank 1..13; held until the next delivery
- o_cardValid  out  1  one-cycle pulse; o_card valid in the same cycle
- o_empty  out  1  one-cycle pulse: request refused, shoe empty
- o_busy  out  1  high in any state other than IDLE
- o_cardsRemaining  out  6  undealt count, 52..0

Behaviour:
- Reset (synchronous):
  - state=IDLE, mask=0, o_cardsRemaining=52.
  - o_card=0, o_cardValid=0, o_empty=0, o_busy=0.
  - lfsr=LFSR_SEED.
  - Reset during SEARCH aborts with no pulse.
- LFSR:
  - Fibonacci, shift left; feedback = l[7]^l[5]^l[4]^l[3].
  - Advances every cycle, and twice when i_stir=1.
  - Never reaches 0.
- Fold: idx = lfsr[5:0]; idx >= 52 maps to idx-52.
- Index-to-card mapping: idx i gives suit = i/13 and rank = (i mod 13)+1.
- States IDLE, SEARCH, DELIVER, EMPTY_ACK:
  - IDLE with i_drawReq in cycle N:
    - remaining>0: cand <= fold(lfsr at cycle N); go to SEARCH.
    - remaining==0 and AUTO_RESHUFFLE=1: mask <= 0, remaining <= 52, cand <= fold; go to SEARCH.
    - remaining==0 and AUTO_RESHUFFLE=0: go to EMPTY_ACK.
  - SEARCH, one candidate per cycle:
    - mask[cand]=0: set mask[cand], remaining--, o_card <= map(cand); go to DELIVER.
    - Otherwise: cand <= (cand==51) ? 0 : cand+1 (wraps 51 to 0).
  - DELIVER: o_cardValid=1 for this one cycle; go to IDLE.
  - EMPTY_ACK: o_empty=1 for one cycle; go to IDLE.
- Latency: request at cycle N gives o_cardValid at N+2+k, where k = probes over dealt cards (0..51). Worst case is N+53.
- i_drawReq outside IDLE is ignored; no queuing. The consumer waits for o_busy=0.
- i_shuffle:
  - In IDLE: mask <= 0, remaining <= 52 next cycle.
  - Same cycle as i_drawReq: the shuffle wins and the request is dropped, with no pulse.
  - In SEARCH, DELIVER or EMPTY_ACK: held pending and applied on return to IDLE. A card already delivered stays delivered.
- o_cardsRemaining changes only on a delivery, a shuffle or a reset.

Decomposition:
- Shared package card_pkg holds:
  - card_t (6-bit packed suit/rank)
  - suit enum SPADES=0, HEARTS=1, DIAMONDS=2, CLUBS=3
  - constants DECK_SIZE=52 and RANK_ACE=1 .. RANK_KING=13
  - shoe_state_t enum
- The game controller's hand/score logic imports card_t from the same package.
- One sub-module, card_lfsr8: seed, stir, 8-bit state output.
- The index-to-card map is a package function; no module.

Test Plan:
- Reset with LFSR_SEED=8'hA5, i_drawReq in the first cycle after reset -> o_cardValid 2 cycles later with o_card={2'd2,4'd12} (idx 37), o_cardsRemaining=51.
- 52 back-to-back draws, each issued on the first cycle o_busy=0 -> 52 distinct cards, each suit with ranks 1..13 once, remaining=0, every latency <= 53.
- AUTO_RESHUFFLE=0, 53rd request -> single o_empty pulse 2 cycles later, no o_cardValid, remaining stays 0. With AUTO_RESHUFFLE=1 -> valid card delivered and remaining=51.
- 51 cards dealt, then a request -> the only remaining card is delivered. Force cand=51 as dealt to check the wrap to idx 0.
- i_drawReq and i_shuffle in the same IDLE cycle -> no pulse, remaining=52. i_shuffle during SEARCH -> the card is delivered, then remaining=52 one cycle after IDLE.
- i_reset asserted mid-SEARCH -> no o_cardValid, all outputs at reset values next cycle, remaining=52.

Source files
------------

// File: rtl/card_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : card_pkg
//  Description : Shared card types and helpers for the card shoe and the
//                blackjack game controller. Holds the 6-bit card encoding,
//                suit/rank constants, shoe state encoding and the
//                index-to-card mapping used by the shoe.
//  Revision    : 1.0 - initial release
// ============================================================================
package card_pkg;

    localparam int DECK_SIZE = 52;

    localparam logic [3:0] RANK_ACE   = 4'd1;
    localparam logic [3:0] RANK_TWO   = 4'd2;
    localparam logic [3:0] RANK_THREE = 4'd3;
    localparam logic [3:0] RANK_FOUR  = 4'd4;
    localparam logic [3:0] RANK_FIVE  = 4'd5;
    localparam logic [3:0] RANK_SIX   = 4'd6;
    localparam logic [3:0] RANK_SEVEN = 4'd7;
    localparam logic [3:0] RANK_EIGHT = 4'd8;
    localparam logic [3:0] RANK_NINE  = 4'd9;
    localparam logic [3:0] RANK_TEN   = 4'd10;
    localparam logic [3:0] RANK_JACK  = 4'd11;
    localparam logic [3:0] RANK_QUEEN = 4'd12;
    localparam logic [3:0] RANK_KING  = 4'd13;

    typedef enum logic [1:0] {
        SPADES   = 2'd0,
        HEARTS   = 2'd1,
        DIAMONDS = 2'd2,
        CLUBS    = 2'd3
    } suit_t;

    // Packed as {suit[5:4], rank[3:0]}
    typedef struct packed {
        suit_t      suit;
        logic [3:0] rank;
    } card_t;

    // Shoe controller state encoding
    typedef logic [1:0] shoe_state_t;
    localparam shoe_state_t c_STATE_IDLE      = 2'd0;
    localparam shoe_state_t c_STATE_SEARCH    = 2'd1;
    localparam shoe_state_t c_STATE_DELIVER   = 2'd2;
    localparam shoe_state_t c_STATE_EMPTY_ACK = 2'd3;

    // Fold the low six LFSR bits (0..63) onto a deck index (0..51).
    function automatic logic [5:0] fold_idx(input logic [7:0] lfsr);
        logic [5:0] raw;
        raw = lfsr[5:0];
        if (raw >= 6'd52) begin
            return raw - 6'd52;
        end
        return raw;
    endfunction

    // Deck index i -> suit i/13, rank (i mod 13)+1. Done with range
    // compares so no divider is inferred.
    function automatic card_t idx_to_card(input logic [5:0] idx);
        card_t      c;
        logic [5:0] offs;
        if (idx < 6'd13) begin
            c.suit = SPADES;
            offs   = idx;
        end else if (idx < 6'd26) begin
            c.suit = HEARTS;
            offs   = idx - 6'd13;
        end else if (idx < 6'd39) begin
            c.suit = DIAMONDS;
            offs   = idx - 6'd26;
        end else begin
            c.suit = CLUBS;
            offs   = idx - 6'd39;
        end
        c.rank = offs[3:0] + 4'd1;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/card_lfsr8.sv
`default_nettype none
// ============================================================================
//  Module      : card_lfsr8
//  Description : Free-running 8-bit Fibonacci LFSR (shift left, feedback
//                l[7]^l[5]^l[4]^l[3]). Steps once per cycle, twice while
//                i_stir is high. A zero seed is replaced by 8'h01 so the
//                register can never lock up at zero.
//  Ports       : i_clk    - system clock
//                i_reset  - synchronous active-high reset (loads seed)
//                i_stir   - extra step this cycle
//                o_state  - current LFSR value
//  Revision    : 1.0 - initial release
// ============================================================================
module card_lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_stir,
    output logic [7:0] o_state
);

    localparam logic [7:0] c_SEED = (SEED == 8'h00) ? 8'h01 : SEED;

    logic [7:0] r_state;
    logic [7:0] w_step1;
    logic [7:0] w_step2;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    always_comb begin
        w_step1 = lfsr_step(r_state);
        w_step2 = lfsr_step(w_step1);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= c_SEED;
        end else if (i_stir) begin
            r_state <= w_step2;
        end else begin
            r_state <= w_step1;
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/card_shoe.sv
`default_nettype none
// ============================================================================
//  Module      : card_shoe
//  Description : Single-deck card shoe. Tracks dealt cards in a 52-bit mask
//                so no card repeats until a reshuffle. A draw request takes
//                a random start index from the LFSR and linearly probes
//                (51 wraps to 0) until an undealt card is found. Every
//                accepted request yields exactly one o_cardValid or one
//                o_empty pulse.
//  Ports       : i_clk            - system clock
//                i_reset          - synchronous active-high reset
//                i_drawReq        - draw request, sampled only when idle
//                i_shuffle        - clear the dealt mask (deferred if busy)
//                i_stir           - extra LFSR step per cycle (entropy)
//                o_card           - last delivered card {suit, rank}
//                o_cardValid      - one-cycle pulse with a new o_card
//                o_empty          - one-cycle pulse, request refused
//                o_busy           - high whenever not idle
//                o_cardsRemaining - undealt card count 52..0
//  Revision    : 1.0 - initial release
// ============================================================================
module card_shoe
    import card_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED      = 8'hA5,
    parameter bit         AUTO_RESHUFFLE = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_drawReq,
    input  logic       i_shuffle,
    input  logic       i_stir,
    output card_t      o_card,
    output logic       o_cardValid,
    output logic       o_empty,
    output logic       o_busy,
    output logic [5:0] o_cardsRemaining
);

    localparam logic [5:0] c_FULL_DECK = 6'(DECK_SIZE);
    localparam logic [5:0] c_LAST_IDX  = 6'(DECK_SIZE - 1);

    shoe_state_t r_state;
    logic [51:0] r_mask;
    logic [5:0]  r_cand;
    logic [5:0]  r_remaining;
    card_t       r_card;
    logic        r_cardValid;
    logic        r_empty;
    logic        r_busy;
    logic        r_shufflePending;

    logic [7:0]  w_lfsr;
    logic [5:0]  w_foldIdx;
    logic [5:0]  w_nextCand;
    logic        w_candDealt;
    logic        w_freshDeck;
    logic        w_canDeal;
    card_t       w_candCard;

    card_lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_stir  (i_stir),
        .o_state (w_lfsr)
    );

    always_comb begin
        w_foldIdx   = fold_idx(w_lfsr);
        w_nextCand  = (r_cand == c_LAST_IDX) ? 6'd0 : r_cand + 6'd1;
        w_candDealt = r_mask[r_cand];
        w_candCard  = idx_to_card(r_cand);
        // A request starts on a cleared deck either because a shuffle was
        // deferred while busy, or because the shoe ran dry and we refill.
        w_freshDeck = r_shufflePending ||
                      ((r_remaining == 6'd0) && AUTO_RESHUFFLE);
        w_canDeal   = w_freshDeck || (r_remaining != 6'd0);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state          <= c_STATE_IDLE;
            r_mask           <= '0;
            r_cand           <= 6'd0;
            r_remaining      <= c_FULL_DECK;
            r_card           <= card_t'(6'd0);
            r_cardValid      <= 1'b0;
            r_empty          <= 1'b0;
            r_busy           <= 1'b0;
            r_shufflePending <= 1'b0;
        end else begin
            r_cardValid <= 1'b0;
            r_empty     <= 1'b0;
            case (r_state)
                c_STATE_IDLE: begin
                    if (i_shuffle) begin
                        // Shuffle wins over a same-cycle request.
                        r_mask           <= '0;
                        r_remaining      <= c_FULL_DECK;
                        r_shufflePending <= 1'b0;
                    end else if (i_drawReq) begin
                        if (w_canDeal) begin
                            if (w_freshDeck) begin
                                r_mask      <= '0;
                                r_remaining <= c_FULL_DECK;
                            end
                            r_shufflePending <= 1'b0;
                            r_cand           <= w_foldIdx;
                            r_state          <= c_STATE_SEARCH;
                        end else begin
                            r_state <= c_STATE_EMPTY_ACK;
                        end
                        r_busy <= 1'b1;
                    end else if (r_shufflePending) begin
                        r_mask           <= '0;
                        r_remaining      <= c_FULL_DECK;
                        r_shufflePending <= 1'b0;
                    end
                end

                c_STATE_SEARCH: begin
                    if (i_shuffle) begin
                        r_shufflePending <= 1'b1;
                    end
                    if (!w_candDealt) begin
                        r_mask[r_cand] <= 1'b1;
                        r_remaining    <= r_remaining - 6'd1;
                        r_card         <= w_candCard;
                        // Pulse coincides with the DELIVER cycle.
                        r_cardValid    <= 1'b1;
                        r_state        <= c_STATE_DELIVER;
                    end else begin
                        r_cand <= w_nextCand;
                    end
                end

                c_STATE_DELIVER: begin
                    if (i_shuffle) begin
                        r_shufflePending <= 1'b1;
                    end
                    r_state <= c_STATE_IDLE;
                    r_busy  <= 1'b0;
                end

                c_STATE_EMPTY_ACK: begin
                    if (i_shuffle) begin
                        r_shufflePending <= 1'b1;
                    end
                    r_empty <= 1'b1;
                    r_state <= c_STATE_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= c_STATE_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_card           = r_card;
    assign o_cardValid      = r_cardValid;
    assign o_empty          = r_empty;
    assign o_busy           = r_busy;
    assign o_cardsRemaining = r_remaining;

endmodule
`default_nettype wire

// File: tb/tb_card_shoe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_card_shoe
//  Description : Directed self-checking bench for card_shoe. Two instances
//                share all inputs: dutA auto-reshuffles, dutB refuses when
//                empty. A small reference model (LFSR, dealt mask) predicts
//                each card and its latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_card_shoe;
    import card_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset   = 1'b1;
    logic drawReq = 1'b0;
    logic shuffle = 1'b0;
    logic stir    = 1'b0;

    card_t      cardA,  cardB;
    logic       validA, validB;
    logic       emptyA, emptyB;
    logic       busyA,  busyB;
    logic [5:0] remA,   remB;

    card_shoe #(.LFSR_SEED(8'hA5), .AUTO_RESHUFFLE(1'b1)) dutA (
        .i_clk(clk), .i_reset(reset), .i_drawReq(drawReq), .i_shuffle(shuffle),
        .i_stir(stir), .o_card(cardA), .o_cardValid(validA), .o_empty(emptyA),
        .o_busy(busyA), .o_cardsRemaining(remA)
    );

    card_shoe #(.LFSR_SEED(8'hA5), .AUTO_RESHUFFLE(1'b0)) dutB (
        .i_clk(clk), .i_reset(reset), .i_drawReq(drawReq), .i_shuffle(shuffle),
        .i_stir(stir), .o_card(cardB), .o_cardValid(validB), .o_empty(emptyB),
        .o_busy(busyB), .o_cardsRemaining(remB)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    logic [7:0] mLfsr;
    bit         mMask [52];
    int         mRem;
    bit         seen  [52];
    int         maxLat;

    function automatic logic [7:0] lstep(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    always @(posedge clk) begin
        if (reset)     mLfsr <= 8'hA5;
        else if (stir) mLfsr <= lstep(lstep(mLfsr));
        else           mLfsr <= lstep(mLfsr);
    end

    function automatic int tbFold(input logic [7:0] l);
        int v;
        v = int'(l[5:0]);
        return (v >= 52) ? v - 52 : v;
    endfunction

    function automatic logic [5:0] tbCard(input int i);
        logic [1:0] s;
        logic [3:0] r;
        s = 2'(i / 13);
        r = 4'((i % 13) + 1);
        return {s, r};
    endfunction

    task automatic clearModel();
        for (int i = 0; i < 52; i++) mMask[i] = 1'b0;
        mRem = 52;
    endtask

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Issue one request in the current (idle) cycle and check the delivery.
    task automatic drawCheck(input string tag, input bit trackSeen);
        int         cand;
        int         k;
        int         lat;
        int         guard;
        int         idx;
        logic [5:0] expCard;
        bit         okRank;
        cand = tbFold(mLfsr);
        k    = 0;
        while (mMask[cand]) begin
            cand = (cand == 51) ? 0 : cand + 1;
            k++;
        end
        mMask[cand] = 1'b1;
        mRem--;
        expCard = tbCard(cand);

        drawReq = 1'b1;
        tick();
        drawReq = 1'b0;
        lat = 1;
        while (!validA && lat < 60) begin
            tick();
            lat++;
        end
        if (lat > maxLat) maxLat = lat;
        check({tag, " latency"}, 16'(lat), 16'(k + 2));
        check({tag, " cardA"}, 16'(cardA), 16'(expCard));
        check({tag, " cardB"}, 16'(cardB), 16'(expCard));
        check({tag, " validB"}, 16'(validB), 16'd1);
        check({tag, " emptyA"}, 16'(emptyA), 16'd0);
        check({tag, " remA"}, 16'(remA), 16'(mRem));
        check({tag, " remB"}, 16'(remB), 16'(mRem));
        if (trackSeen) begin
            okRank = (cardA.rank >= 4'd1) && (cardA.rank <= 4'd13);
            check({tag, " rank range"}, 16'(okRank), 16'd1);
            if (okRank) begin
                idx = 13 * int'(cardA.suit) + int'(cardA.rank) - 1;
                check({tag, " unique"}, 16'(seen[idx]), 16'd0);
                seen[idx] = 1'b1;
            end
        end
        tick();
        guard = 0;
        while (busyA && guard < 5) begin
            tick();
            guard++;
        end
        check({tag, " idle after"}, 16'(busyA), 16'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int         cand;
        int         nSeen;
        bit         pulse;
        logic [5:0] expCard;

        maxLat = 0;
        for (int i = 0; i < 52; i++) seen[i] = 1'b0;
        clearModel();

        // Reset
        tick();
        tick();
        reset = 1'b0;
        check("reset remA", 16'(remA), 16'd52);
        check("reset remB", 16'(remB), 16'd52);
        check("reset card", 16'(cardA), 16'd0);
        check("reset valid", 16'(validA), 16'd0);
        check("reset empty", 16'(emptyA), 16'd0);
        check("reset busy", 16'(busyA), 16'd0);

        // First draw straight after reset: idx 37 -> {DIAMONDS, 12}
        drawCheck("draw0", 1'b1);
        check("first card const", 16'(cardA), 16'h002C);
        check("first rem const", 16'(remA), 16'd51);

        // Remaining 51 draws back to back, stirring on some of them
        for (int j = 1; j < 52; j++) begin
            stir = ((j % 4) == 1);
            drawCheck($sformatf("draw%0d", j), 1'b1);
        end
        stir = 1'b0;
        nSeen = 0;
        for (int i = 0; i < 52; i++) if (seen[i]) nSeen++;
        check("distinct cards", 16'(nSeen), 16'd52);
        check("deck empty A", 16'(remA), 16'd0);
        check("deck empty B", 16'(remB), 16'd0);
        check("max latency <= 53", 16'(maxLat <= 53), 16'd1);

        // 53rd request: A reshuffles and deals, B refuses
        cand = tbFold(mLfsr);
        expCard = tbCard(cand);
        drawReq = 1'b1;
        tick();
        drawReq = 1'b0;
        check("req53 validA early", 16'(validA), 16'd0);
        check("req53 emptyB early", 16'(emptyB), 16'd0);
        check("req53 busyB", 16'(busyB), 16'd1);
        tick();
        check("req53 validA", 16'(validA), 16'd1);
        check("req53 cardA", 16'(cardA), 16'(expCard));
        check("req53 remA", 16'(remA), 16'd51);
        check("req53 emptyA", 16'(emptyA), 16'd0);
        check("req53 emptyB", 16'(emptyB), 16'd1);
        check("req53 validB", 16'(validB), 16'd0);
        check("req53 remB", 16'(remB), 16'd0);
        tick();
        check("req53 emptyB single", 16'(emptyB), 16'd0);
        check("req53 validB late", 16'(validB), 16'd0);
        check("req53 busyB idle", 16'(busyB), 16'd0);
        check("req53 busyA idle", 16'(busyA), 16'd0);

        // Shuffle both shoes in idle
        shuffle = 1'b1;
        tick();
        shuffle = 1'b0;
        check("shuffle remA", 16'(remA), 16'd52);
        check("shuffle remB", 16'(remB), 16'd52);
        clearModel();

        // Request and shuffle in the same idle cycle: request dropped
        drawCheck("pre-pair", 1'b0);
        drawReq = 1'b1;
        shuffle = 1'b1;
        tick();
        drawReq = 1'b0;
        shuffle = 1'b0;
        check("pair busy", 16'(busyA), 16'd0);
        check("pair remA", 16'(remA), 16'd52);
        pulse = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (validA || emptyA || validB || emptyB) pulse = 1'b1;
            tick();
        end
        check("pair no pulse", 16'(pulse), 16'd0);
        clearModel();

        // Shuffle during SEARCH: card still delivered, deck cleared after
        cand = tbFold(mLfsr);
        expCard = tbCard(cand);
        drawReq = 1'b1;
        tick();
        drawReq = 1'b0;
        shuffle = 1'b1;
        check("mid shuffle busy", 16'(busyA), 16'd1);
        tick();
        shuffle = 1'b0;
        check("mid shuffle valid", 16'(validA), 16'd1);
        check("mid shuffle card", 16'(cardA), 16'(expCard));
        check("mid shuffle rem", 16'(remA), 16'd51);
        tick();
        check("mid shuffle idle", 16'(busyA), 16'd0);
        check("mid shuffle rem idle", 16'(remA), 16'd51);
        tick();
        check("mid shuffle applied A", 16'(remA), 16'd52);
        check("mid shuffle applied B", 16'(remB), 16'd52);
        clearModel();

        // Reset during SEARCH aborts silently
        drawCheck("pre-reset", 1'b0);
        drawReq = 1'b1;
        tick();
        drawReq = 1'b0;
        check("abort busy", 16'(busyA), 16'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort valid", 16'(validA), 16'd0);
        check("abort card", 16'(cardA), 16'd0);
        check("abort rem", 16'(remA), 16'd52);
        check("abort busy clr", 16'(busyA), 16'd0);
        check("abort empty", 16'(emptyA), 16'd0);
        clearModel();

        // LFSR reseeded: first draw is idx 37 again
        drawCheck("post-reset", 1'b0);
        check("post-reset card const", 16'(cardA), 16'h002C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
